// File: rtl/multu_hilo_unit.sv
// Iterative shift-and-add unsigned multiplier (MULTU) holding the architectural HI/LO pair.
// A product takes WIDTH cycles; busy stalls the pipeline and done pulses when HI/LO update.
module multu_hilo_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;

    // NOTE: combinational logic uses blocking assignment and gives every output a value
    // on every path, so no latch is inferred.
    always_comb begin
        acc_next = acc;
        if (mplier[0]) begin
            acc_next = acc + mcand;
        end
    end

    // NOTE: all state updates here are non-blocking so every register samples
    // pre-edge values; reset is synchronous, so it is tested inside the clocked block.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    // A start in the DONE cycle chains straight into the next product.
                    if (start) begin
                        state  <= RUN;
                        busy   <= 1'b1;
                        mcand  <= {{WIDTH{1'b0}}, srca};
                        mplier <= srcb;
                        acc    <= '0;
                        cnt    <= CW'(WIDTH);
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        hi    <= acc_next[2*WIDTH-1:WIDTH];
                        lo    <= acc_next[WIDTH-1:0];
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
